// File: rtl/exec_controller.sv
// Multi-cycle instruction sequencer: latches an instruction on a synchronized
// EXECUTE rise and steps T0..T3, driving bus, register-file and ALU controls.
module exec_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EXECUTE,
    input  logic [9:0] INSTR,
    output logic [1:0] TIME,
    output logic       DONE,
    output logic       EXT_OE,
    output logic       REG_OE,
    output logic       G_OE,
    output logic       RIN,
    output logic [2:0] WADDR,
    output logic [2:0] RADDR,
    output logic       AIN,
    output logic       GIN,
    output logic [3:0] ALU_OP
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_COPY = 4'd1;

    step_t                  state_r;
    step_t                  state_next_s;
    logic [9:0]             ir_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   prev_r;
    logic                   sync_out_s;
    logic                   filled_s;
    logic                   rise_s;
    logic                   start_s;
    logic                   is_alu_s;
    logic [3:0]             op_s;
    logic [2:0]             rx_s;
    logic [2:0]             ry_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign filled_s   = fill_r[SYNC_STAGES-1];
    assign rise_s     = sync_out_s & ~prev_r;
    assign start_s    = rise_s & (state_r == T0);

    assign op_s     = ir_r[9:6];
    assign rx_s     = ir_r[5:3];
    assign ry_s     = ir_r[2:0];
    assign is_alu_s = (op_s >= 4'd2) && (op_s <= 4'd5);

    assign TIME = state_r;

    // EXECUTE synchronizer and edge detector. The previous-value flop is held
    // at 1 until the synchronizer has refilled after reset, so a button held
    // through reset never looks like a fresh rise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_r <= '0;
            fill_r <= '0;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], EXECUTE};
            fill_r <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            prev_r <= filled_s ? sync_out_s : 1'b1;
        end
    end

    // Timestep register and instruction register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= T0;
            ir_r    <= 10'd0;
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                ir_r <= INSTR;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-step selection; every instruction ends by returning to T0.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            T0: begin
                if (start_s) begin
                    state_next_s = T1;
                end else begin
                    state_next_s = T0;
                end
            end
            T1: begin
                if (is_alu_s) begin
                    state_next_s = T2;
                end else begin
                    state_next_s = T0;
                end
            end
            T2:      state_next_s = T3;
            T3:      state_next_s = T0;
            default: state_next_s = T0;
        endcase
    end

    // Moore control outputs decoded from the current step and IR.
    always_comb begin
        DONE   = 1'b0;
        EXT_OE = 1'b0;
        REG_OE = 1'b0;
        G_OE   = 1'b0;
        RIN    = 1'b0;
        WADDR  = 3'd0;
        RADDR  = 3'd0;
        AIN    = 1'b0;
        GIN    = 1'b0;
        ALU_OP = op_s;
        case (state_r)
            T0: begin
                RADDR = ry_s;
            end
            T1: begin
                if (op_s == OP_LOAD) begin
                    EXT_OE = 1'b1;
                    RIN    = 1'b1;
                    WADDR  = rx_s;
                    DONE   = 1'b1;
                end else if (op_s == OP_COPY) begin
                    RADDR  = ry_s;
                    REG_OE = 1'b1;
                    RIN    = 1'b1;
                    WADDR  = rx_s;
                    DONE   = 1'b1;
                end else if (is_alu_s) begin
                    RADDR  = rx_s;
                    REG_OE = 1'b1;
                    AIN    = 1'b1;
                end else begin
                    DONE = 1'b1;
                end
            end
            T2: begin
                if (is_alu_s) begin
                    RADDR  = ry_s;
                    REG_OE = 1'b1;
                    GIN    = 1'b1;
                end else begin
                    RADDR = 3'd0;
                end
            end
            T3: begin
                if (is_alu_s) begin
                    G_OE  = 1'b1;
                    RIN   = 1'b1;
                    WADDR = rx_s;
                    DONE  = 1'b1;
                end else begin
                    DONE = 1'b0;
                end
            end
            default: begin
                DONE = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exec_controller.sv
// Directed self-checking bench for exec_controller.
module tb_exec_controller;

    localparam int SYNC = 2;

    logic       CLK;
    logic       RST;
    logic       EXECUTE;
    logic [9:0] INSTR;
    logic [1:0] TIME;
    logic       DONE;
    logic       EXT_OE;
    logic       REG_OE;
    logic       G_OE;
    logic       RIN;
    logic [2:0] WADDR;
    logic [2:0] RADDR;
    logic       AIN;
    logic       GIN;
    logic [3:0] ALU_OP;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    exec_controller #(.SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .RST(RST), .EXECUTE(EXECUTE), .INSTR(INSTR),
        .TIME(TIME), .DONE(DONE), .EXT_OE(EXT_OE), .REG_OE(REG_OE),
        .G_OE(G_OE), .RIN(RIN), .WADDR(WADDR), .RADDR(RADDR),
        .AIN(AIN), .GIN(GIN), .ALU_OP(ALU_OP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        EXECUTE = 1'b0;
        repeat (n) tick();
    endtask

    // Packs all one-bit enables: {EXT_OE, REG_OE, G_OE, RIN, AIN, GIN, DONE}.
    function automatic logic [31:0] ens();
        return {25'd0, EXT_OE, REG_OE, G_OE, RIN, AIN, GIN, DONE};
    endfunction

    task automatic start_instr(input logic [9:0] instr);
        INSTR   = instr;
        EXECUTE = 1'b1;
        repeat (SYNC) tick();
        check("pre_start_time", 32'(TIME), 32'd0);
        tick();
        check("start_time", 32'(TIME), 32'd1);
    endtask

    int done_cnt;
    logic [2:0] t1_raddr;
    logic [2:0] t1_waddr;

    initial begin
        RST = 1'b1; EXECUTE = 1'b0; INSTR = 10'd0;
        repeat (3) tick();
        check("rst_time", 32'(TIME), 32'd0);
        check("rst_ens", ens(), 32'd0);
        check("rst_raddr", 32'(RADDR), 32'd0);
        RST = 1'b0;
        idle_cycles(4);

        // LOAD R3
        start_instr(10'h018);
        check("load_t1_ens", ens(), 32'b1001001);
        check("load_waddr", 32'(WADDR), 32'd3);
        EXECUTE = 1'b0;
        tick();
        check("load_t0_time", 32'(TIME), 32'd0);
        check("load_t0_done", 32'(DONE), 32'd0);
        idle_cycles(4);

        // ADD R1,R2
        start_instr(10'h08A);
        EXECUTE = 1'b0;
        check("add_t1_ens", ens(), 32'b0100100);
        check("add_t1_raddr", 32'(RADDR), 32'd1);
        tick();
        check("add_t2_time", 32'(TIME), 32'd2);
        check("add_t2_ens", ens(), 32'b0100010);
        check("add_t2_raddr", 32'(RADDR), 32'd2);
        check("add_t2_aluop", 32'(ALU_OP), 32'd2);
        tick();
        check("add_t3_time", 32'(TIME), 32'd3);
        check("add_t3_ens", ens(), 32'b0011001);
        check("add_t3_waddr", 32'(WADDR), 32'd1);
        tick();
        check("add_t0_time", 32'(TIME), 32'd0);
        check("add_t0_ens", ens(), 32'd0);
        check("add_t0_raddr", 32'(RADDR), 32'd2);
        idle_cycles(4);

        // SUB R7,R0 with a new synchronized rise landing while busy
        INSTR = 10'h0F8; EXECUTE = 1'b1;
        repeat (SYNC) tick();
        EXECUTE = 1'b0;
        tick();
        check("sub_t1_time", 32'(TIME), 32'd1);
        EXECUTE = 1'b1;
        tick();
        check("sub_t2_time", 32'(TIME), 32'd2);
        check("sub_t2_aluop", 32'(ALU_OP), 32'd3);
        tick();
        check("sub_t3_ens", ens(), 32'b0011001);
        check("sub_t3_waddr", 32'(WADDR), 32'd7);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (TIME != 2'd0) done_cnt++;
        end
        check("sub_no_restart", 32'(done_cnt), 32'd0);
        idle_cycles(4);

        // COPY R2,R1 with EXECUTE held for 20 cycles
        INSTR = 10'h051; EXECUTE = 1'b1;
        done_cnt = 0; t1_raddr = 3'd0; t1_waddr = 3'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE) done_cnt++;
            if (TIME == 2'd1) begin
                t1_raddr = RADDR;
                t1_waddr = WADDR;
            end
        end
        check("copy_done_cnt", 32'(done_cnt), 32'd1);
        check("copy_raddr", 32'(t1_raddr), 32'd1);
        check("copy_waddr", 32'(t1_waddr), 32'd2);
        idle_cycles(4);

        // Undefined opcode 15
        start_instr(10'h3C0);
        EXECUTE = 1'b0;
        check("undef_t1_ens", ens(), 32'b0000001);
        tick();
        check("undef_t0_time", 32'(TIME), 32'd0);
        check("undef_t0_ens", ens(), 32'd0);
        idle_cycles(4);

        // Reset in T2 of an ADD, button held through reset
        start_instr(10'h08A);
        tick();
        check("rst_pre_t2", 32'(TIME), 32'd2);
        #2 RST = 1'b1;
        #1;
        check("rst_async_time", 32'(TIME), 32'd0);
        check("rst_async_ens", ens(), 32'd0);
        tick();
        RST = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (RIN || TIME != 2'd0) done_cnt++;
        end
        check("rst_held_no_start", 32'(done_cnt), 32'd0);
        idle_cycles(4);

        // Fresh press after reset still works
        start_instr(10'h018);
        check("post_rst_load_waddr", 32'(WADDR), 32'd3);
        EXECUTE = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
